piso_serializer: RTL

Parallel-in, serial-out transmitter for the shift-register family. It accepts a WIDTH-bit word through a valid/ready load handshake and emits it one bit per clock on `serial_out`, with framing strobes a downstream serial-in register can use to recover word boundaries. It supports back-to-back words with no idle gap, so a continuous stream can be driven into SISO/SIPO chains.

---
 rtl/piso_serializer.sv | 127 ++++++++++++
 1 files changed

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in, serial-out transmitter.
//
// Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out
// one bit per clock on serial_out. A word may be accepted during the last
// bit of the previous one, so back-to-back words stream with no idle gap.
//
// Parameters:
//   WIDTH     word width in bits (>= 2)
//   MSB_FIRST 1: bit WIDTH-1 goes out first, 0: bit 0 goes out first
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   parallel_in  word to transmit, sampled only on handshake
//   load_valid   source has a word on parallel_in
//   load_ready   block can accept a word this cycle (from state only)
//   serial_out   current serial bit (registered)
//   out_valid    serial_out carries a data bit (registered)
//   frame_start  first bit of a word is on serial_out (registered)
//   frame_last   last bit of a word is on serial_out (registered)
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] parallel_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             serial_out,
    output logic             out_valid,
    output logic             frame_start,
    output logic             frame_last
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             serial_out_q, serial_out_d;
    logic             out_valid_q, out_valid_d;
    logic             frame_start_q, frame_start_d;
    logic             frame_last_q, frame_last_d;

    logic             at_last;
    logic             take;
    logic [CNT_W-1:0] cnt_inc;
    logic [WIDTH-1:0] shreg_nxt;

    // The bit on serial_out is always the "head" of the shift register,
    // so the registered output is computed from the next register value.
    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    always_comb begin
        at_last    = (state_q == S_SHIFT) && (cnt_q == CNT_LAST);
        load_ready = (state_q == S_IDLE) || at_last;
        take       = load_valid && load_ready;
        cnt_inc    = cnt_q + 1'b1;
        shreg_nxt  = shift_once(shreg_q);

        state_d       = state_q;
        cnt_d         = cnt_q;
        shreg_d       = shreg_q;
        serial_out_d  = 1'b0;
        out_valid_d   = 1'b0;
        frame_start_d = 1'b0;
        frame_last_d  = 1'b0;

        if (take) begin
            // Fresh word (from IDLE or chained onto the last bit).
            state_d       = S_SHIFT;
            cnt_d         = '0;
            shreg_d       = parallel_in;
            serial_out_d  = head_bit(parallel_in);
            out_valid_d   = 1'b1;
            frame_start_d = 1'b1;
        end else if (state_q == S_SHIFT) begin
            if (!at_last) begin
                cnt_d        = cnt_inc;
                shreg_d      = shreg_nxt;
                serial_out_d = head_bit(shreg_nxt);
                out_valid_d  = 1'b1;
                frame_last_d = (cnt_inc == CNT_LAST);
            end else begin
                // Word done and nothing queued: outputs drop to 0.
                state_d = S_IDLE;
                cnt_d   = '0;
                shreg_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            shreg_q       <= '0;
            serial_out_q  <= 1'b0;
            out_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            frame_last_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            shreg_q       <= shreg_d;
            serial_out_q  <= serial_out_d;
            out_valid_q   <= out_valid_d;
            frame_start_q <= frame_start_d;
            frame_last_q  <= frame_last_d;
        end
    end

    assign serial_out  = serial_out_q;
    assign out_valid   = out_valid_q;
    assign frame_start = frame_start_q;
    assign frame_last  = frame_last_q;

endmodule
